// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter
// Purpose  : Round-robin sequencer that shares one multi-cycle divider core
//            between N_REQ requesters. It latches the winner's operands,
//            launches the core and returns the quotient with a one-cycle ack.
//            A zero divisor skips the core, and a watchdog aborts a hung core.
// Revision : 1.0 - initial release
// ============================================================================
module div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               reset_i,       // synchronous, active-low
  input  logic               clk_en_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*W-1:0] dataa_in_i,
  input  logic [N_REQ*W-1:0] datab_in_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic [W-1:0]       result_o,
  output logic               dz_o,
  output logic               err_o,
  output logic               busy_o,
  output logic [W-1:0]       div_dataa_o,
  output logic [W-1:0]       div_datab_o,
  output logic               div_start_o,
  output logic               div_reset_o,
  output logic               div_clk_en_o,
  input  logic [W-1:0]       div_result_i,
  input  logic               div_done_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] C_WDOG_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    grant_q;
  logic [IW-1:0]    ptr_q;
  logic [7:0]       wdog_q;
  logic [N_REQ-1:0] ack_q;
  logic [W-1:0]     result_q;
  logic             dz_q;
  logic             err_q;
  logic [W-1:0]     dataa_q;
  logic [W-1:0]     datab_q;
  logic             start_q;
  logic             core_rst_q;

  logic             gnt_vld;
  logic [IW-1:0]    gnt_sel;
  logic [IW:0]      scan_idx;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Cyclic priority search: first requesting bit at or after the rr pointer.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_sel  = '0;
    scan_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(N_REQ)) begin
        scan_idx = scan_idx - (IW+1)'(N_REQ);
      end
      if (!gnt_vld && req_i[scan_idx[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_sel = scan_idx[IW-1:0];
      end
    end
  end

  assign sel_a = dataa_in_i[gnt_sel*W +: W];
  assign sel_b = datab_in_i[gnt_sel*W +: W];

  // Sequencer FSM; every output is registered. The core reset pulse is
  // self-clearing on every clock so it never stretches across a stall.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      wdog_q     <= '0;
      ack_q      <= '0;
      result_q   <= '0;
      dz_q       <= 1'b0;
      err_q      <= 1'b0;
      dataa_q    <= '0;
      datab_q    <= '0;
      start_q    <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      core_rst_q <= 1'b0;
      if (clk_en_i) begin
        case (state_q)
          S_IDLE: begin
            if (gnt_vld) begin
              grant_q <= gnt_sel;
              dataa_q <= sel_a;
              datab_q <= sel_b;
              if (sel_b == '0) begin
                // Divide-by-zero never touches the core.
                result_q <= '1;
                dz_q     <= 1'b1;
                ack_q    <= onehot(gnt_sel);
                state_q  <= S_RESP;
              end else begin
                start_q <= 1'b1;
                state_q <= S_LAUNCH;
              end
            end
          end
          S_LAUNCH: begin
            start_q <= 1'b0;
            wdog_q  <= '0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (div_done_i) begin
              // A done coinciding with the last watchdog cycle still wins.
              result_q <= div_result_i;
              ack_q    <= onehot(grant_q);
              state_q  <= S_RESP;
            end else if (wdog_q == C_WDOG_LAST) begin
              result_q   <= '0;
              err_q      <= 1'b1;
              core_rst_q <= 1'b1;
              ack_q      <= onehot(grant_q);
              state_q    <= S_RESP;
            end else begin
              wdog_q <= wdog_q + 8'd1;
            end
          end
          S_RESP: begin
            ack_q   <= '0;
            dz_q    <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ack_o        = ack_q;
  assign result_o     = result_q;
  assign dz_o         = dz_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != S_IDLE);
  assign div_dataa_o  = dataa_q;
  assign div_datab_o  = datab_q;
  assign div_start_o  = start_q;
  assign div_reset_o  = core_rst_q;
  assign div_clk_en_o = clk_en_i;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_arbiter
// Purpose  : Directed self-checking bench for div_arbiter with a small
//            behavioural divider core (fixed latency, optional hang).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           clk_en = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] da = '0;
  logic [N*W-1:0] db = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   result;
  logic           dz, err, busy;
  logic [W-1:0]   div_dataa, div_datab;
  logic           div_start, div_reset, div_clk_en;
  logic [W-1:0]   div_result = '0;
  logic           div_done = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int starts = 0;
  int dresets = 0;

  logic hang = 1'b0;
  logic m_busy = 1'b0;
  int   m_cnt = 0;

  div_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(255)) dut (
    .clk_i(clk), .reset_i(reset_n), .clk_en_i(clk_en), .req_i(req),
    .dataa_in_i(da), .datab_in_i(db), .ack_o(ack), .result_o(result),
    .dz_o(dz), .err_o(err), .busy_o(busy), .div_dataa_o(div_dataa),
    .div_datab_o(div_datab), .div_start_o(div_start), .div_reset_o(div_reset),
    .div_clk_en_o(div_clk_en), .div_result_i(div_result), .div_done_i(div_done)
  );

  always #5 clk = ~clk;

  // Divider core model: fixed latency after start, can be made to hang.
  always @(posedge clk) begin
    if (div_reset) begin
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      div_done <= 1'b0;
    end else if (div_clk_en) begin
      div_done <= 1'b0;
      if (div_start) begin
        m_busy <= 1'b1;
        m_cnt  <= LAT;
      end else if (m_busy && !hang) begin
        if (m_cnt == 1) begin
          div_done   <= 1'b1;
          div_result <= div_dataa / div_datab;
          m_busy     <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Count accepted start pulses and core-reset cycles.
  always @(posedge clk) begin
    if (div_start === 1'b1 && div_clk_en === 1'b1) starts <= starts + 1;
    if (div_reset === 1'b1) dresets <= dresets + 1;
  end

  task automatic wait_ack(input int budget, output int cyc, output logic to);
    cyc = 0;
    to  = 1'b1;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (|ack) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL rst_ack: got %b want 0000", ack); end
    n_vec++; if (result !== 32'h0) begin n_bad++; $display("FAIL rst_result: got %h want 0", result); end
    n_vec++; if ({dz, err, div_start} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {dz, err, div_start}); end
    n_vec++; if (div_reset !== 1'b1) begin n_bad++; $display("FAIL rst_divreset: got %b want 1", div_reset); end
    n_vec++; if ({div_dataa, div_datab} !== 64'h0) begin n_bad++; $display("FAIL rst_operands: got %h want 0", {div_dataa, div_datab}); end
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (div_reset !== 1'b0) begin n_bad++; $display("FAIL rst_release_divreset: got %b want 0", div_reset); end
  endtask

  task automatic test_single;
    int cyc; logic to; int s0;
    s0 = starts;
    da[0*W +: W] = 32'd100; db[0*W +: W] = 32'd7;
    req = 4'b0001;
    wait_ack(40, cyc, to);
    n_vec++; if (to !== 1'b0) begin n_bad++; $display("FAIL single_timeout: got no ack want ack"); end
    n_vec++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL single_ack: got %b want 0001", ack); end
    n_vec++; if (result !== 32'd14) begin n_bad++; $display("FAIL single_result: got %0d want 14", result); end
    n_vec++; if ({dz, err} !== 2'b00) begin n_bad++; $display("FAIL single_flags: got %b want 00", {dz, err}); end
    req = '0;
    @(negedge clk);
    n_vec++; if (starts - s0 !== 1) begin n_bad++; $display("FAIL single_starts: got %0d want 1", starts - s0); end
    n_vec++; if ({busy, ack} !== 5'b0) begin n_bad++; $display("FAIL single_idle: got %b want 00000", {busy, ack}); end
  endtask

  task automatic test_round_robin;
    int cyc; logic to;
    logic [W-1:0] exp_q [4];
    logic [N-1:0] exp_a;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    da = {32'd1000, 32'd200, 32'd99, 32'd60};
    db = {32'd10,   32'd8,   32'd9,  32'd5};
    exp_q = '{32'd12, 32'd11, 32'd25, 32'd100};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(40, cyc, to);
      exp_a = 4'b0001 << k;
      n_vec++; if (ack !== exp_a) begin n_bad++; $display("FAIL rr_order%0d: got %b want %b", k, ack, exp_a); end
      n_vec++; if (result !== exp_q[k]) begin n_bad++; $display("FAIL rr_result%0d: got %0d want %0d", k, result, exp_q[k]); end
      req = req & ~ack;
    end
    @(negedge clk);
    req = 4'b1001;
    wait_ack(40, cyc, to);
    n_vec++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL rr_batch2_first: got %b want 0001", ack); end
    req = req & ~ack;
    wait_ack(40, cyc, to);
    n_vec++; if (ack !== 4'b1000) begin n_bad++; $display("FAIL rr_batch2_second: got %b want 1000", ack); end
    n_vec++; if (result !== 32'd100) begin n_bad++; $display("FAIL rr_batch2_result: got %0d want 100", result); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    int s0;
    s0 = starts;
    da[2*W +: W] = 32'd5; db[2*W +: W] = 32'd0;
    req = 4'b0100;
    @(negedge clk);
    n_vec++; if (ack !== 4'b0100) begin n_bad++; $display("FAIL dz_ack: got %b want 0100", ack); end
    n_vec++; if (result !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_result: got %h want ffffffff", result); end
    n_vec++; if ({dz, err} !== 2'b10) begin n_bad++; $display("FAIL dz_flags: got %b want 10", {dz, err}); end
    req = '0;
    @(negedge clk);
    n_vec++; if ({dz, ack} !== 5'b0) begin n_bad++; $display("FAIL dz_clear: got %b want 00000", {dz, ack}); end
    n_vec++; if (starts - s0 !== 0) begin n_bad++; $display("FAIL dz_nostart: got %0d want 0", starts - s0); end
  endtask

  task automatic test_timeout;
    int cyc; logic to; int dr0;
    hang = 1'b1;
    dr0 = dresets;
    da[0*W +: W] = 32'd50; db[0*W +: W] = 32'd5;
    req = 4'b0001;
    wait_ack(400, cyc, to);
    n_vec++; if (to !== 1'b0) begin n_bad++; $display("FAIL wd_noack: got no ack want ack"); end
    n_vec++; if (cyc !== 257) begin n_bad++; $display("FAIL wd_latency: got %0d want 257", cyc); end
    n_vec++; if ({ack, err, dz} !== 6'b0001_10) begin n_bad++; $display("FAIL wd_flags: got %b want 000110", {ack, err, dz}); end
    n_vec++; if (result !== 32'h0) begin n_bad++; $display("FAIL wd_result: got %h want 0", result); end
    n_vec++; if (div_reset !== 1'b1) begin n_bad++; $display("FAIL wd_divreset: got %b want 1", div_reset); end
    req = '0;
    @(negedge clk);
    n_vec++; if ({div_reset, err} !== 2'b00) begin n_bad++; $display("FAIL wd_clear: got %b want 00", {div_reset, err}); end
    n_vec++; if (dresets - dr0 !== 1) begin n_bad++; $display("FAIL wd_pulse_len: got %0d want 1", dresets - dr0); end
    hang = 1'b0;
    da[0*W +: W] = 32'd81; db[0*W +: W] = 32'd9;
    req = 4'b0001;
    wait_ack(40, cyc, to);
    n_vec++; if ({ack, err} !== 5'b0001_0 || result !== 32'd9) begin n_bad++; $display("FAIL wd_recover: got ack=%b err=%b q=%0d want 0001 0 9", ack, err, result); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc; logic to;
    hang = 1'b1;
    da[1*W +: W] = 32'd70; db[1*W +: W] = 32'd7;
    req = 4'b0010;
    repeat (10) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    req = '0;
    reset_n = 1'b0;
    @(negedge clk);
    n_vec++; if ({busy, ack, div_reset} !== 6'b0_0000_1) begin n_bad++; $display("FAIL mid_abort: got %b want 000001", {busy, ack, div_reset}); end
    reset_n = 1'b1;
    hang = 1'b0;
    @(negedge clk);
    da[0*W +: W] = 32'hFFFF_FFFF; db[0*W +: W] = 32'd1;
    req = 4'b0001;
    wait_ack(40, cyc, to);
    n_vec++; if (ack !== 4'b0001 || result !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mid_after: got ack=%b q=%h want 0001 ffffffff", ack, result); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_clk_en;
    int s0; int acks; logic [W-1:0] q; logic [N-1:0] a;
    clk_en = 1'b0;
    #1;
    n_vec++; if (div_clk_en !== 1'b0) begin n_bad++; $display("FAIL ce_passthru: got %b want 0", div_clk_en); end
    clk_en = 1'b1;
    s0 = starts; acks = 0; q = '0; a = '0;
    da[1*W +: W] = 32'd1000; db[1*W +: W] = 32'd10;
    req = 4'b0010;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (|ack) begin
        acks++;
        q   = result;
        a   = ack;
        req = '0;
      end else if (acks > 0) begin
        break;
      end
      clk_en = ~clk_en;
    end
    clk_en = 1'b1;
    n_vec++; if (acks !== 2) begin n_bad++; $display("FAIL ce_ack_len: got %0d want 2", acks); end
    n_vec++; if (a !== 4'b0010 || q !== 32'd100) begin n_bad++; $display("FAIL ce_result: got ack=%b q=%0d want 0010 100", a, q); end
    n_vec++; if (starts - s0 !== 1) begin n_bad++; $display("FAIL ce_starts: got %0d want 1", starts - s0); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_div_zero();
    test_timeout();
    test_reset_mid();
    test_clk_en();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
